// File: rtl/result_reader_if.sv
// ---------------------------------------------------------------------------
// result_reader_if
// Bundles the two data paths of the result reader:
//   - output-SRAM read port : sram_rd_en, sram_addr (reader -> SRAM),
//                             sram_data (SRAM -> reader, 1-cycle latency)
//   - host stream           : m_valid, m_data, m_last (reader -> host),
//                             m_ready (host -> reader)
// Modport master is the reader side; modport slave is the SRAM/host side.
// ---------------------------------------------------------------------------
interface result_reader_if #(
  parameter int DATAWIDTH        = 32,
  parameter int O_DATA_ADDRWIDTH = 16
);
  logic                        sram_rd_en;
  logic [O_DATA_ADDRWIDTH-1:0] sram_addr;
  logic [DATAWIDTH-1:0]        sram_data;
  logic                        m_valid;
  logic                        m_ready;
  logic [DATAWIDTH-1:0]        m_data;
  logic                        m_last;

  modport master (
    output sram_rd_en, sram_addr, m_valid, m_data, m_last,
    input  sram_data, m_ready
  );

  modport slave (
    input  sram_rd_en, sram_addr, m_valid, m_data, m_last,
    output sram_data, m_ready
  );
endinterface

// File: rtl/result_reader.sv
// ---------------------------------------------------------------------------
// result_reader
// Drains rd_len result words from the co-processor output SRAM to a
// valid/ready host stream once the co-processor signals completion.
//
// Ports:
//   clk        - single clock, rising edge
//   rstn       - synchronous active-low reset
//   finish_sig - co-processor done level; a rising edge in IDLE starts a drain
//   rd_len     - number of words to drain, sampled at the start edge
//   bus        - result_reader_if.master: SRAM read port + host stream
//   busy       - high while in RUN
//   done       - one-cycle pulse when the drain completes
//
// Words are read in address order 0..len-1, land in a 2-entry FIFO one cycle
// after the read strobe, and are presented from the FIFO head to the host.
// ---------------------------------------------------------------------------
module result_reader #(
  parameter int DATAWIDTH        = 32,
  parameter int O_DATA_ADDRWIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    finish_sig,
  input  logic [O_DATA_ADDRWIDTH:0] rd_len,
  result_reader_if.master         bus,
  output logic                    busy,
  output logic                    done
);

  localparam int AW = O_DATA_ADDRWIDTH;
  // One extra bit so a full 2^AW drain counts to 2^AW instead of wrapping.
  localparam int CW = O_DATA_ADDRWIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH
  } state_t;

  state_t               state, state_nxt;

  logic                 fin_q;
  logic                 armed;
  logic                 rise;

  logic [CW-1:0]        len_q;
  logic [CW-1:0]        issue_cnt;
  logic [CW-1:0]        deliv_cnt;
  logic                 rd_pending;
  logic                 rd_en;

  logic [DATAWIDTH-1:0] fifo_mem [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           fifo_cnt;
  logic                 push;
  logic                 pop;
  logic                 head_last;
  logic [2:0]           credit;

  // -------------------------------------------------------------------------
  // Start detection. armed stays low until finish_sig has been seen low after
  // reset, so a level already high at reset release cannot start a drain.
  // -------------------------------------------------------------------------
  assign rise = finish_sig & ~fin_q & armed;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      fin_q <= 1'b0;
      armed <= 1'b0;
    end else begin
      fin_q <= finish_sig;
      armed <= armed | ~finish_sig;
    end
  end

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Slots committed after this edge: FIFO contents plus the read in flight,
  // less the word the host takes this cycle. Counting the same-cycle pop is
  // what lets a back-to-back stream run at one word per cycle while never
  // holding more than two words between SRAM and host.
  assign credit = {1'b0, fifo_cnt} + {2'b00, rd_pending} - {2'b00, pop};

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    case (state)
      S_IDLE: begin
        if (rise) state_nxt = (rd_len == '0) ? S_FLUSH : S_RUN;
      end
      S_RUN: begin
        rd_en = (issue_cnt < len_q) && (credit < 3'd2);
        if (pop && head_last) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_FLUSH);

  // -------------------------------------------------------------------------
  // Issue / delivery counters and read-in-flight tracking.
  // rd_pending is cleared by reset, so data returning for a read issued just
  // before reset is never pushed.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      len_q      <= '0;
      issue_cnt  <= '0;
      deliv_cnt  <= '0;
      rd_pending <= 1'b0;
    end else begin
      rd_pending <= rd_en;
      if (state == S_IDLE && rise) begin
        len_q     <= rd_len;
        issue_cnt <= '0;
        deliv_cnt <= '0;
      end else begin
        if (rd_en) issue_cnt <= issue_cnt + CW'(1);
        if (pop)   deliv_cnt <= deliv_cnt + CW'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // 2-entry FIFO
  // -------------------------------------------------------------------------
  assign push = rd_pending;
  assign pop  = bus.m_valid & bus.m_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  // NOTE: the storage array is deliberately not reset; an entry is only
  // visible once fifo_cnt says it was written, and m_data is forced to zero
  // while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.sram_data;
  end

  assign head_last = (deliv_cnt == len_q - CW'(1));

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.sram_rd_en = rd_en;
  assign bus.sram_addr  = issue_cnt[AW-1:0];
  assign bus.m_valid    = (fifo_cnt != 2'd0);
  assign bus.m_data     = bus.m_valid ? fifo_mem[rd_ptr] : '0;
  assign bus.m_last     = bus.m_valid & head_last;

endmodule
